// File: rtl/ex_ls_q_pkg.sv
// Shared encodings for the queued load/store execution unit: op codes, widths, len and rw_flag
// encodings, FSM states and small op-decode helpers.
package ex_ls_q_pkg;

  localparam int unsigned NEWOP_W    = 4;
  localparam int unsigned TAG_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  // The free tag is all-ones at any tag width.
  localparam logic [TAG_WIDTH-1:0] TAG_FREE = '1;

  localparam logic [NEWOP_W-1:0] LB  = 4'd0;
  localparam logic [NEWOP_W-1:0] LH  = 4'd1;
  localparam logic [NEWOP_W-1:0] LW  = 4'd2;
  localparam logic [NEWOP_W-1:0] LBU = 4'd3;
  localparam logic [NEWOP_W-1:0] LHU = 4'd4;
  localparam logic [NEWOP_W-1:0] SB  = 4'd5;
  localparam logic [NEWOP_W-1:0] SH  = 4'd6;
  localparam logic [NEWOP_W-1:0] SW  = 4'd7;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain
  } ls_state_e;

  // Unknown op codes fall through to a word access.
  function automatic logic [1:0] op_len(input logic [NEWOP_W-1:0] op);
    case (op)
      LB, LBU, SB: return LEN_B;
      LH, LHU, SH: return LEN_H;
      default:     return LEN_W;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [NEWOP_W-1:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] addr_lo, input logic [1:0] len);
    case (len)
      LEN_H:   return addr_lo[0];
      LEN_W:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ls_op_queue.sv
// In-order FIFO for accepted memory ops with a synchronous flush. DEPTH must be a power of two
// so the read and write pointers wrap naturally.
module ls_op_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ex_ls_q.sv
// Queued load/store execution unit: buffers ops in order, issues them one at a time to mem_ctrl,
// short-circuits misaligned accesses and drains an in-flight access after a flush.
module ex_ls_q
  import ex_ls_q_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_WIDTH,
  parameter int unsigned ADDR_W      = ADDR_WIDTH,
  parameter int unsigned TAG_W       = TAG_WIDTH,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               ex_ls_en,
  input  logic [DATA_W-1:0]  ex_src1,
  input  logic [DATA_W-1:0]  ex_src2,
  input  logic [DATA_W-1:0]  ex_reg,
  input  logic [NEWOP_W-1:0] ex_lsop,
  input  logic [TAG_W-1:0]   ex_dest,
  output logic               ex_ls_ready,
  output logic               en_rst,
  output logic [DATA_W-1:0]  rst_data,
  output logic [TAG_W-1:0]   rst_tag,
  output logic               rst_misalign,
  output logic [1:0]         rw_flag,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  write_data,
  output logic [1:0]         len,
  input  logic [DATA_W-1:0]  read_data,
  input  logic               mem_busy,
  input  logic               mem_done
);

  localparam int unsigned CountW = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [NEWOP_W-1:0] op;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t            q_wdata, q_rdata;
  logic              q_push, q_pop, q_flush, q_full, q_empty;
  logic [CountW-1:0] q_count;
  logic              unused_q_count;
  logic              pop_req;

  logic [DATA_W-1:0] ea_sum;
  logic [1:0]        head_len;
  logic              head_store, head_mis;

  ls_state_e          state_q, state_d;
  logic               en_rst_q, en_rst_d;
  logic [DATA_W-1:0]  rst_data_q, rst_data_d;
  logic [TAG_W-1:0]   rst_tag_q, rst_tag_d;
  logic               rst_misalign_q, rst_misalign_d;
  logic [1:0]         rw_flag_q, rw_flag_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;
  logic [1:0]         len_q, len_d;
  logic [NEWOP_W-1:0] cur_op_q, cur_op_d;
  logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;

  function automatic logic [DATA_W-1:0] load_extend(input logic [NEWOP_W-1:0] op,
                                                    input logic [DATA_W-1:0]  d);
    case (op)
      LB:      return {{(DATA_W - 8){d[7]}}, d[7:0]};
      LBU:     return {{(DATA_W - 8){1'b0}}, d[7:0]};
      LH:      return {{(DATA_W - 16){d[15]}}, d[15:0]};
      LHU:     return {{(DATA_W - 16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign ea_sum = ex_src1 + ex_src2;

  always_comb begin
    q_wdata      = '0;
    q_wdata.addr = ADDR_W'(ea_sum);
    q_wdata.op   = ex_lsop;
    q_wdata.tag  = ex_dest;
    q_wdata.data = ex_reg;
  end

  // Readiness does not count a same-cycle pop, so a full queue never accepts.
  assign ex_ls_ready    = rdy & ~rst & ~q_full;
  assign q_push         = ex_ls_en & ex_ls_ready & ~clear;
  assign q_flush        = rdy & clear;
  assign q_pop          = pop_req & rdy;
  assign unused_q_count = ^q_count;

  ls_op_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (q_flush),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign head_len   = op_len(q_rdata.op);
  assign head_store = op_is_store(q_rdata.op);
  assign head_mis   = ALIGN_CHECK && addr_misaligned(q_rdata.addr[1:0], head_len);

  always_comb begin
    state_d        = state_q;
    en_rst_d       = 1'b0;
    rst_data_d     = rst_data_q;
    rst_tag_d      = rst_tag_q;
    rst_misalign_d = 1'b0;
    rw_flag_d      = RW_NONE;
    addr_d         = addr_q;
    write_data_d   = write_data_q;
    len_d          = len_q;
    cur_op_d       = cur_op_q;
    cur_tag_d      = cur_tag_q;
    pop_req        = 1'b0;

    if (clear) begin
      // An access already in flight must still see its mem_done before new ops issue.
      if ((state_q == StWait || state_q == StDrain) && !mem_done) begin
        state_d = StDrain;
      end else begin
        state_d      = StIdle;
        addr_d       = '0;
        write_data_d = '0;
        len_d        = LEN_B;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (!q_empty && !mem_busy) begin
            pop_req = 1'b1;
            if (head_mis) begin
              en_rst_d       = 1'b1;
              rst_misalign_d = 1'b1;
              rst_data_d     = '0;
              rst_tag_d      = q_rdata.tag;
            end else begin
              rw_flag_d    = head_store ? RW_WRITE : RW_READ;
              addr_d       = q_rdata.addr;
              len_d        = head_len;
              write_data_d = head_store ? q_rdata.data : '0;
              cur_op_d     = q_rdata.op;
              cur_tag_d    = q_rdata.tag;
              state_d      = StWait;
            end
          end
        end
        StWait: begin
          if (mem_done) begin
            en_rst_d     = 1'b1;
            rst_tag_d    = cur_tag_q;
            rst_data_d   = op_is_store(cur_op_q) ? '0 : load_extend(cur_op_q, read_data);
            addr_d       = '0;
            write_data_d = '0;
            len_d        = LEN_B;
            state_d      = StIdle;
          end
        end
        StDrain: begin
          if (mem_done) begin
            addr_d       = '0;
            write_data_d = '0;
            len_d        = LEN_B;
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      en_rst_q       <= 1'b0;
      rst_data_q     <= '0;
      rst_tag_q      <= '1;
      rst_misalign_q <= 1'b0;
      rw_flag_q      <= RW_NONE;
      addr_q         <= '0;
      write_data_q   <= '0;
      len_q          <= LEN_B;
      cur_op_q       <= '0;
      cur_tag_q      <= '0;
    end else if (rdy) begin
      state_q        <= state_d;
      en_rst_q       <= en_rst_d;
      rst_data_q     <= rst_data_d;
      rst_tag_q      <= rst_tag_d;
      rst_misalign_q <= rst_misalign_d;
      rw_flag_q      <= rw_flag_d;
      addr_q         <= addr_d;
      write_data_q   <= write_data_d;
      len_q          <= len_d;
      cur_op_q       <= cur_op_d;
      cur_tag_q      <= cur_tag_d;
    end
  end

  assign en_rst       = en_rst_q;
  assign rst_data     = rst_data_q;
  assign rst_tag      = rst_tag_q;
  assign rst_misalign = rst_misalign_q;
  assign rw_flag      = rw_flag_q;
  assign addr         = addr_q;
  assign write_data   = write_data_q;
  assign len          = len_q;

endmodule

// File: tb/tb_ex_ls_q.sv
// Scoreboard bench for ex_ls_q: expected requests/results are queued at issue time and popped by
// monitors whenever the DUT drives rw_flag or en_rst.
module tb_ex_ls_q;
  import ex_ls_q_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = TAG_WIDTH;

  logic          clk = 1'b0;
  logic          rst, rdy, clear, ex_ls_en, ex_ls_en2;
  logic [DW-1:0] ex_src1, ex_src2, ex_reg;
  logic [NEWOP_W-1:0] ex_lsop;
  logic [TW-1:0] ex_dest;
  logic          mem_busy, mem_done, mem_done2;
  logic [DW-1:0] read_data, read_data2;

  logic          ex_ls_ready, en_rst, rst_misalign;
  logic [DW-1:0] rst_data, write_data;
  logic [TW-1:0] rst_tag;
  logic [1:0]    rw_flag, len;
  logic [AW-1:0] addr;

  logic          ex_ls_ready2, en_rst2, rst_misalign2;
  logic [DW-1:0] rst_data2, write_data2;
  logic [TW-1:0] rst_tag2;
  logic [1:0]    rw_flag2, len2;
  logic [AW-1:0] addr2;

  always #5 clk = ~clk;

  ex_ls_q #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .QUEUE_DEPTH(4), .ALIGN_CHECK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .ex_ls_en(ex_ls_en),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_reg(ex_reg), .ex_lsop(ex_lsop), .ex_dest(ex_dest),
    .ex_ls_ready(ex_ls_ready), .en_rst(en_rst), .rst_data(rst_data), .rst_tag(rst_tag),
    .rst_misalign(rst_misalign), .rw_flag(rw_flag), .addr(addr), .write_data(write_data),
    .len(len), .read_data(read_data), .mem_busy(mem_busy), .mem_done(mem_done)
  );

  ex_ls_q #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW), .QUEUE_DEPTH(4), .ALIGN_CHECK(1'b0)) u_dut_na (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .ex_ls_en(ex_ls_en2),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_reg(ex_reg), .ex_lsop(ex_lsop), .ex_dest(ex_dest),
    .ex_ls_ready(ex_ls_ready2), .en_rst(en_rst2), .rst_data(rst_data2), .rst_tag(rst_tag2),
    .rst_misalign(rst_misalign2), .rw_flag(rw_flag2), .addr(addr2), .write_data(write_data2),
    .len(len2), .read_data(read_data2), .mem_busy(mem_busy), .mem_done(mem_done2)
  );

  typedef struct {
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          mis;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  int errors = 0;
  int checks = 0;

  int            mem_lat  = 3;
  bit            mem_hold = 1'b0;
  int            done_cnt = 0;
  logic [DW-1:0] rd_val   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_req(input logic [1:0] rw, input logic [AW-1:0] a, input logic [1:0] l,
                         input logic [DW-1:0] wd);
    req_t r;
    r.rw = rw; r.addr = a; r.len = l; r.wd = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_res(input logic [TW-1:0] tag, input logic [DW-1:0] d, input logic mis);
    res_t e;
    e.tag = tag; e.data = d; e.mis = mis;
    res_q.push_back(e);
  endtask

  // Simple mem_ctrl: answers each request mem_lat cycles after it is seen.
  initial begin
    int cnt;
    cnt = 0;
    mem_done = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst) cnt = 0;
      else if (rw_flag != RW_NONE) cnt = mem_lat;
      else if (cnt > 0 && !mem_hold) begin
        cnt--;
        if (cnt == 0) begin
          mem_done  = 1'b1;
          read_data = rd_val;
          done_cnt++;
        end
      end
    end
  end

  // Monitor: every request and every result must match the head of its expectation queue.
  initial begin
    req_t r;
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && rw_flag != RW_NONE) begin
        if (req_q.size() == 0) chk("unexpected_req", rw_flag, RW_NONE);
        else begin
          r = req_q.pop_front();
          chk("req_rw", rw_flag, r.rw);
          chk("req_addr", addr, r.addr);
          chk("req_len", len, r.len);
          chk("req_wdata", write_data, r.wd);
        end
      end
      if (!rst && en_rst) begin
        if (res_q.size() == 0) chk("unexpected_en_rst", en_rst, 1'b0);
        else begin
          e = res_q.pop_front();
          chk("res_tag", rst_tag, e.tag);
          chk("res_data", rst_data, e.data);
          chk("res_misalign", rst_misalign, e.mis);
        end
      end
    end
  end

  task automatic enq(input logic [NEWOP_W-1:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                     input logic [DW-1:0] rg, input logic [TW-1:0] tag);
    int n;
    n = 0;
    while (!ex_ls_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ex_ls_ready) chk("enq_ready_timeout", ex_ls_ready, 1'b1);
    ex_lsop = op; ex_src1 = s1; ex_src2 = s2; ex_reg = rg; ex_dest = tag;
    ex_ls_en = 1'b1;
    @(posedge clk); #1;
    ex_ls_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((req_q.size() != 0 || res_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", req_q.size() + res_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_en_rst"}, en_rst, 1'b0);
    chk({tagname, "_rst_data"}, rst_data, '0);
    chk({tagname, "_rst_tag"}, rst_tag, TAG_FREE);
    chk({tagname, "_rst_misalign"}, rst_misalign, 1'b0);
    chk({tagname, "_rw_flag"}, rw_flag, RW_NONE);
    chk({tagname, "_addr"}, addr, '0);
    chk({tagname, "_write_data"}, write_data, '0);
    chk({tagname, "_len"}, len, 2'b00);
    chk({tagname, "_ready"}, ex_ls_ready, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; ex_ls_en = 1'b0; ex_ls_en2 = 1'b0;
    ex_src1 = '0; ex_src2 = '0; ex_reg = '0; ex_lsop = LB; ex_dest = '0;
    mem_busy = 1'b0; mem_done2 = 1'b0; read_data2 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", ex_ls_ready, 1'b1);
    @(posedge clk); #1;

    // ALIGN_CHECK=0 instance: misaligned LW goes to memory as a normal read.
    ex_lsop = LW; ex_src1 = 32'h100; ex_src2 = 32'h2; ex_reg = '0; ex_dest = 5'd7;
    ex_ls_en2 = 1'b1;
    @(posedge clk); #1;
    ex_ls_en2 = 1'b0;
    @(posedge clk); #1;
    chk("na_rw_flag", rw_flag2, RW_READ);
    chk("na_addr", addr2, 32'h102);
    chk("na_len", len2, LEN_W);
    mem_done2 = 1'b1; read_data2 = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_done2 = 1'b0;
    chk("na_en_rst", en_rst2, 1'b1);
    chk("na_rst_data", rst_data2, 32'hCAFEF00D);
    chk("na_rst_tag", rst_tag2, 5'd7);
    chk("na_rst_misalign", rst_misalign2, 1'b0);
    chk("na_rw_pulse", rw_flag2, RW_NONE);
    @(posedge clk); #1;
    chk("na_en_rst_pulse", en_rst2, 1'b0);

    // Single loads and stores.
    mem_lat = 3; rd_val = 32'h000000F0;
    exp_req(RW_READ, 32'h104, LEN_B, '0); exp_res(5'd5, 32'hFFFFFFF0, 1'b0);
    enq(LB, 32'h100, 32'h4, '0, 5'd5);
    wait_drain();
    exp_req(RW_READ, 32'h104, LEN_B, '0); exp_res(5'd6, 32'h000000F0, 1'b0);
    enq(LBU, 32'h100, 32'h4, '0, 5'd6);
    wait_drain();
    exp_req(RW_WRITE, 32'h200, LEN_W, 32'hDEADBEEF); exp_res(5'd2, '0, 1'b0);
    enq(SW, 32'h200, 32'h0, 32'hDEADBEEF, 5'd2);
    wait_drain();
    exp_res(5'd7, '0, 1'b1);
    enq(LW, 32'h100, 32'h2, '0, 5'd7);
    wait_drain();
    exp_res(5'd3, '0, 1'b1);
    enq(LH, 32'h101, 32'h0, '0, 5'd3);
    wait_drain();
    rd_val = 32'h0000007F;
    exp_req(RW_READ, 32'h103, LEN_B, '0); exp_res(5'd4, 32'h0000007F, 1'b0);
    enq(LB, 32'h103, 32'h0, '0, 5'd4);
    wait_drain();
    rd_val = 32'hABCD8001;
    exp_req(RW_READ, 32'h106, LEN_H, '0); exp_res(5'd8, 32'hFFFF8001, 1'b0);
    enq(LH, 32'h100, 32'h6, '0, 5'd8);
    exp_req(RW_READ, 32'h106, LEN_H, '0); exp_res(5'd9, 32'h00008001, 1'b0);
    enq(LHU, 32'h100, 32'h6, '0, 5'd9);
    exp_req(RW_READ, 32'h108, LEN_W, '0); exp_res(5'd1, 32'hABCD8001, 1'b0);
    enq(LW, 32'h108, 32'h0, '0, 5'd1);
    exp_req(RW_WRITE, 32'h202, LEN_H, 32'h1234ABCD); exp_res(5'd11, '0, 1'b0);
    enq(SH, 32'h200, 32'h2, 32'h1234ABCD, 5'd11);
    wait_drain();

    // Fill the queue behind mem_busy, then let five ops complete in order.
    mem_busy = 1'b1; mem_lat = 2; rd_val = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      exp_req(RW_READ, 32'h300 + 32'(4 * i), LEN_W, '0);
      exp_res(TW'(10 + i), 32'h11223344, 1'b0);
      enq(LW, 32'h300, 32'(4 * i), '0, TW'(10 + i));
      chk("ready_fill", ex_ls_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    exp_req(RW_READ, 32'h310, LEN_W, '0); exp_res(5'd14, 32'h11223344, 1'b0);
    mem_busy = 1'b0;
    enq(LW, 32'h300, 32'h10, '0, 5'd14);
    wait_drain();

    // Flush in WAIT with two queued ops; the same-cycle enqueue is dropped.
    mem_lat = 6; rd_val = 32'h00000055;
    exp_req(RW_READ, 32'h400, LEN_W, '0);
    enq(LW, 32'h400, 32'h0, '0, 5'd20);
    enq(LW, 32'h404, 32'h0, '0, 5'd21);
    enq(SW, 32'h408, 32'h0, 32'h77, 5'd22);
    d0 = done_cnt;
    clear = 1'b1;
    ex_lsop = LW; ex_src1 = 32'h40C; ex_src2 = '0; ex_dest = 5'd23; ex_ls_en = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; ex_ls_en = 1'b0;
    mem_lat = 2;
    exp_req(RW_READ, 32'h500, LEN_W, '0); exp_res(5'd24, 32'h00000055, 1'b0);
    enq(LW, 32'h500, 32'h0, '0, 5'd24);
    n = 0;
    while (req_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_before_issue", (done_cnt > d0) ? 1'b1 : 1'b0, 1'b1);
    wait_drain();

    // Reset in the middle of WAIT with another op queued.
    mem_lat = 5;
    exp_req(RW_READ, 32'h600, LEN_W, '0);
    enq(LW, 32'h600, 32'h0, '0, 5'd25);
    enq(LB, 32'h604, 32'h0, '0, 5'd26);
    n = 0;
    while (req_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // rdy low freezes a queued op.
    mem_busy = 1'b1; mem_lat = 2; rd_val = 32'h00000099;
    exp_req(RW_READ, 32'h700, LEN_W, '0); exp_res(5'd27, 32'h00000099, 1'b0);
    enq(LW, 32'h700, 32'h0, '0, 5'd27);
    rdy = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rdy_low_rw_flag", rw_flag, RW_NONE);
      chk("rdy_low_ready", ex_ls_ready, 1'b0);
    end
    rdy = 1'b1;
    wait_drain();

    chk("final_req_q", req_q.size(), 0);
    chk("final_res_q", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
